// File: rtl/result_stream_buffer.sv
// Result snapshot buffer: single-cycle capture of a NUM_WORDS x WORD_W vector, drained as a valid/ready stream or by indexed reads.
// Optional macro RESULT_BUF_RELU_EN rectifies negative words on capture.
module result_stream_buffer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 256,
  localparam int IDX_W    = $clog2(NUM_WORDS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_capture,
  input  logic [NUM_WORDS*WORD_W-1:0] i_data,
  input  logic                        i_stream_start,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic [WORD_W-1:0]           o_data,
  output logic                        o_last,
  input  logic                        i_rd_en,
  input  logic [IDX_W-1:0]            i_rd_idx,
  output logic [WORD_W-1:0]           o_rd_data,
  output logic                        o_loaded,
  output logic                        o_busy,
  output logic                        o_overrun,
  input  logic                        i_clr_ovr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W:0]   NUM_WORDS_X = (IDX_W+1)'(NUM_WORDS);

  function automatic logic [WORD_W-1:0] rectify(input logic [WORD_W-1:0] w);
`ifdef RESULT_BUF_RELU_EN
    if (w[WORD_W-1]) begin
      return {WORD_W{1'b0}};
    end else begin
      return w;
    end
`else
    return w;
`endif
  endfunction

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        ptr_nxt;
  logic                    valid_q, valid_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic                    last_q, last_d;
  logic                    loaded_q, loaded_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;
  logic [WORD_W-1:0]       rd_data_q, rd_data_d;
  logic [WORD_W-1:0]       mem_q [NUM_WORDS];
  logic [WORD_W-1:0]       mem_d [NUM_WORDS];
  logic                    capture_ok;

  // Next-state logic for the FSM, stream pointer/outputs, overrun and read port.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    ovr_d      = ovr_q;
    rd_data_d  = {WORD_W{1'b0}};
    mem_d      = mem_q;
    ptr_nxt    = ptr_q + IDX_W'(1);
    capture_ok = i_capture && (state_q != ST_STREAM);

    if (capture_ok) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        mem_d[k] = rectify(i_data[(NUM_WORDS-k)*WORD_W-1 -: WORD_W]);
      end
    end else begin
      mem_d = mem_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_capture) begin
          state_d = ST_LOADED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOADED: begin
        // The stream always starts from the snapshot already held before this edge.
        if (i_stream_start) begin
          state_d = ST_STREAM;
          ptr_d   = {IDX_W{1'b0}};
          valid_d = 1'b1;
          data_d  = mem_q[0];
          last_d  = 1'b0;
        end else begin
          state_d = ST_LOADED;
        end
      end
      ST_STREAM: begin
        if (valid_q && i_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = ST_IDLE;
            ptr_d   = {IDX_W{1'b0}};
            valid_d = 1'b0;
            data_d  = {WORD_W{1'b0}};
            last_d  = 1'b0;
          end else begin
            ptr_d   = ptr_nxt;
            data_d  = mem_q[ptr_nxt];
            last_d  = (ptr_nxt == LAST_IDX);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = {IDX_W{1'b0}};
        valid_d = 1'b0;
        data_d  = {WORD_W{1'b0}};
        last_d  = 1'b0;
      end
    endcase

    if (i_capture && (state_q == ST_STREAM)) begin
      ovr_d = 1'b1;
    end else if (i_clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (i_rd_en && ({1'b0, i_rd_idx} < NUM_WORDS_X)) begin
      rd_data_d = mem_q[i_rd_idx];
    end else begin
      rd_data_d = {WORD_W{1'b0}};
    end

    loaded_d = (state_d != ST_IDLE);
    busy_d   = (state_d == ST_STREAM);
  end

  // State, buffer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= {IDX_W{1'b0}};
      valid_q   <= 1'b0;
      data_q    <= {WORD_W{1'b0}};
      last_q    <= 1'b0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rd_data_q <= {WORD_W{1'b0}};
      for (int k = 0; k < NUM_WORDS; k++) begin
        mem_q[k] <= {WORD_W{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      loaded_q  <= loaded_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      rd_data_q <= rd_data_d;
      mem_q     <= mem_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;
  assign o_loaded  = loaded_q;
  assign o_busy    = busy_q;
  assign o_overrun = ovr_q;
  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_result_stream_buffer.sv
// Self-checking bench for result_stream_buffer: directed sequences, a read-vector table and a randomized phase against a snapshot/queue-level model.
module tb_result_stream_buffer;
  localparam int W = 32;
  localparam int N = 256;
  localparam int IW = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic            capture;
  logic [N*W-1:0]  data;
  logic            start;
  logic            ready;
  logic            valid;
  logic [W-1:0]    odata;
  logic            last;
  logic            rd_en;
  logic [IW-1:0]   rd_idx;
  logic [W-1:0]    rd_data;
  logic            loaded;
  logic            busy;
  logic            ovr;
  logic            clr;

  result_stream_buffer #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_capture(capture), .i_data(data),
    .i_stream_start(start), .i_ready(ready), .o_valid(valid), .o_data(odata),
    .o_last(last), .i_rd_en(rd_en), .i_rd_idx(rd_idx), .o_rd_data(rd_data),
    .o_loaded(loaded), .o_busy(busy), .o_overrun(ovr), .i_clr_ovr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the held snapshot, whether it is being streamed, and which word is on offer.
  logic [W-1:0] m_buf [N];
  bit           m_held;
  bit           m_str;
  int           m_idx;
  bit           m_ovr;
  logic [W-1:0] m_rd;

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef RESULT_BUF_RELU_EN
    return ($signed(v) < 0) ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_buf[k] = 32'd0;
    m_held = 1'b0;
    m_str  = 1'b0;
    m_idx  = 0;
    m_ovr  = 1'b0;
    m_rd   = 32'd0;
  endtask

  task automatic model_edge();
    bit held0;
    bit str0;
    held0 = m_held;
    str0  = m_str;
    m_rd = (rd_en && (int'(rd_idx) < N)) ? m_buf[rd_idx] : 32'd0;
    if (capture && str0) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (capture && !str0) begin
      for (int k = 0; k < N; k++) m_buf[k] = relu(data[(N-k)*W-1 -: W]);
      m_held = 1'b1;
    end
    if (str0) begin
      if (ready) begin
        if (m_idx == N-1) begin
          m_str  = 1'b0;
          m_held = 1'b0;
        end else begin
          m_idx++;
        end
      end
    end else if (held0 && start) begin
      m_str = 1'b1;
      m_idx = 0;
    end
  endtask

  task automatic compare_all();
    check("valid",   {31'd0, valid},  {31'd0, m_str});
    check("data",    odata,           m_str ? m_buf[m_idx] : 32'd0);
    check("last",    {31'd0, last},   {31'd0, (m_str && m_idx == N-1)});
    check("loaded",  {31'd0, loaded}, {31'd0, m_held});
    check("busy",    {31'd0, busy},   {31'd0, m_str});
    check("overrun", {31'd0, ovr},    {31'd0, m_ovr});
    check("rd_data", rd_data,         m_rd);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    capture = 1'b0;
    start   = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic set_word(input int k, input logic [W-1:0] v);
    data[(N-k)*W-1 -: W] = v;
  endtask

  typedef struct {
    logic          en;
    logic [IW-1:0] idx;
    logic [W-1:0]  exp;
  } rd_vec_t;

  rd_vec_t vecs [6];
  bit      pat [4];

  initial begin
    rst_n = 1'b0; capture = 1'b0; data = '0; start = 1'b0; ready = 1'b0;
    rd_en = 1'b0; rd_idx = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counting pattern streamed at full rate.
    for (int k = 0; k < N; k++) set_word(k, W'(k + 1));
    capture = 1'b1; step();
    start = 1'b1; ready = 1'b1; step();
    check("first_word", odata, 32'd1);
    for (int c = 0; c < N + 2 && m_str; c++) step();
    check("end_valid", {31'd0, valid}, 32'd0);
    check("end_loaded", {31'd0, loaded}, 32'd0);

    // Same snapshot again with ready toggled 1,0,0,1.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    capture = 1'b1; step();
    start = 1'b1; step();
    for (int c = 0; c < 3*N && m_str; c++) begin
      ready = pat[c % 4];
      step();
    end
    check("toggle_done", {31'd0, busy}, 32'd0);

    // Overrun: capture B mid-stream is dropped; set beats clear.
    ready = 1'b1;
    for (int k = 0; k < N; k++) set_word(k, W'(k*3 + 7));
    capture = 1'b1; step();
    start = 1'b1; step();
    while (m_idx < 10) step();
    for (int k = 0; k < N; k++) set_word(k, 32'hBBBB_0000 + W'(k));
    capture = 1'b1; step();
    check("ovr_set", {31'd0, ovr}, 32'd1);
    check("word11_from_a", odata, 32'd40);
    while (m_idx < 20) step();
    capture = 1'b1; clr = 1'b1; step();
    check("ovr_set_wins", {31'd0, ovr}, 32'd1);
    for (int c = 0; c < N && m_str; c++) step();
    check("ovr_sticky", {31'd0, ovr}, 32'd1);
    clr = 1'b1; step();
    check("ovr_cleared", {31'd0, ovr}, 32'd0);

    // Random-access reads from a table.
    for (int k = 0; k < N; k++) set_word(k, 32'hA000_0000 + W'(k));
    capture = 1'b1; step();
    vecs[0] = '{1'b1, IW'(0),   32'hA000_0000};
    vecs[1] = '{1'b1, IW'(255), 32'hA000_00FF};
    vecs[2] = '{1'b1, IW'(17),  32'hA000_0011};
    vecs[3] = '{1'b0, IW'(17),  32'h0000_0000};
    vecs[4] = '{1'b1, IW'(128), 32'hA000_0080};
    vecs[5] = '{1'b0, IW'(0),   32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      rd_en = vecs[i].en; rd_idx = vecs[i].idx;
      step();
      check("table_rd", rd_data, vecs[i].exp);
    end

    // Rectification of a negative word versus a positive one.
    set_word(3, 32'hFFFF_FFFE);
    set_word(4, 32'h0000_0005);
    capture = 1'b1; step();
    rd_en = 1'b1; rd_idx = IW'(3); step();
`ifdef RESULT_BUF_RELU_EN
    check("relu_neg", rd_data, 32'h0000_0000);
`else
    check("relu_neg", rd_data, 32'hFFFF_FFFE);
`endif
    rd_idx = IW'(4); step();
    check("relu_pos", rd_data, 32'h0000_0005);
    rd_en = 1'b0;

    // Reset in the middle of a stream.
    start = 1'b1; step();
    while (m_idx < 100) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid",  {31'd0, valid},  32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    check("rst_data",   odata,           32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; step();
    check("start_ignored", {31'd0, valid}, 32'd0);
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      capture = ($urandom_range(0, 19) == 0);
      start   = !capture && ($urandom_range(0, 9) == 0);
      clr     = ($urandom_range(0, 15) == 0);
      ready   = ($urandom_range(0, 3) != 0);
      rd_en   = $urandom_range(0, 1) == 1;
      rd_idx  = IW'($urandom_range(0, N-1));
      if (capture) begin
        for (int k = 0; k < N; k++) set_word(k, W'($urandom));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/result_stream_buffer.md
Name: result_stream_buffer

Overview:
- Parametrised successor to the PIM result-capture buffer.
- Snapshots a NUM_WORDS x WORD_W result vector from the PIM macro in a single cycle.
- Returns the snapshot to the core in two ways: as a valid/ready word stream (for the DMA / bus bridge), or by registered random-access index reads.
- Adds occupancy state, a sticky overrun flag and a last-word marker.

Parameters:
- WORD_W, 32, bits per result word.
- NUM_WORDS, 256, number of words per snapshot (any value >= 2, need not be a power of 2).
- IDX_W, $clog2(NUM_WORDS), width of word index/pointer (derived; do not override).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_capture  in  1  one-cycle pulse: snapshot i_data.
- i_data  in  NUM_WORDS*WORD_W  PIM result vector; word k = i_data[(NUM_WORDS-k)*WORD_W-1 -: WORD_W] (word 0 is the MSB slice).
- i_stream_start  in  1  pulse: begin streaming the held snapshot.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_valid  out  1  o_data holds a valid stream word.
- o_data  out  WORD_W  stream word.
- o_last  out  1  high with o_valid on word NUM_WORDS-1.
- i_rd_en  in  1  random-access read request.
- i_rd_idx  in  IDX_W  random-access word index.
- o_rd_data  out  WORD_W  random-access read data.
- o_loaded  out  1  a snapshot is held and not yet fully streamed.
- o_busy  out  1  streaming in progress.
- o_overrun  out  1  sticky: a capture was dropped.
- i_clr_ovr  in  1  clears o_overrun.

Behaviour:
- Reset (async assert, sync release): state IDLE, ptr=0. All outputs 0. Buffer contents are cleared to 0.
- States:
  - IDLE: no snapshot held.
  - LOADED: snapshot held, not streaming.
  - STREAM: words being emitted.
- Transitions:
  - IDLE --i_capture--> LOADED.
  - LOADED --i_capture--> LOADED; buffer is overwritten with the new vector and no overrun is flagged.
  - LOADED --i_stream_start--> STREAM, ptr=0.
  - STREAM --(o_valid & i_ready & ptr==NUM_WORDS-1)--> IDLE.
  - i_stream_start in IDLE or STREAM is ignored.
- Capture: all NUM_WORDS words are written on the clock edge where i_capture=1, in IDLE or LOADED only.
- Capture during STREAM: the vector is dropped, buffer is unchanged, and o_overrun is set from the next cycle.
- Overrun flag:
  - o_overrun is cleared by i_clr_ovr.
  - If set and clear happen in the same cycle, set wins.
- Stream:
  - o_valid rises the cycle after the accepted i_stream_start.
  - o_data = buffer[ptr], registered. o_data and o_last remain stable while o_valid & !i_ready.
  - On o_valid & i_ready, ptr increments and the next word appears the following cycle, giving 1 word/cycle throughput with i_ready held high.
  - After the last handshake, o_valid and o_last drop the next cycle. o_data is 0 whenever o_valid=0.
- Status outputs:
  - o_loaded=1 in LOADED and STREAM.
  - o_busy=1 in STREAM.
- Random-access read:
  - 1-cycle latency: o_rd_data = buffer[i_rd_idx] the cycle after i_rd_en=1; otherwise 0.
  - i_rd_idx >= NUM_WORDS returns 0.
  - Allowed in any state, independent of the stream, with no effect on ptr.
  - Read on the same edge as a capture returns the pre-capture word.
- Reset mid-stream: immediate return to IDLE and o_valid=0; the partial stream is abandoned.

Optional Feature:
- Macro: RESULT_BUF_RELU_EN.
- When defined: each word is interpreted as signed two's complement on capture, and negative words are stored as 0 (ReLU). The transform is applied in the capture path only, so stream and random reads both see the rectified values.
- When undefined: words are stored bit-exact.

Test Plan:
- Reset then capture i_data with word k = k+1; stream with i_ready=1 -> o_data = 1..256 on 256 consecutive cycles, o_last only with 256, then o_valid=0 and o_loaded=0.
- Stream with i_ready toggled 1,0,0,1 -> no word skipped or duplicated; o_data/o_last stable while stalled.
- Capture pattern A, i_stream_start, capture pattern B at word 10 -> B dropped, remaining words still from A, o_overrun=1 until i_clr_ovr pulse.
- Random reads of idx 0, 255, 17 after capturing word k = 32'hA000_0000+k -> o_rd_data = A0000000, A00000FF, A0000011 one cycle later; i_rd_en=0 gives 0.
- With RESULT_BUF_RELU_EN, capture word 3 = 32'hFFFF_FFFE and word 4 = 32'h0000_0005 -> reads return 0 and 5; without the macro they return FFFFFFFE and 5.
- Assert i_rst_n=0 at word 100 of a stream -> o_valid, o_busy and o_loaded are 0 immediately; i_stream_start afterwards is ignored until a new capture.
